// File: rtl/usb_ep_buf_mgr_if.sv
// usb_ep_buf_mgr_if: application/engine bus of the endpoint buffer manager.
// Ports: app-side IN fill + OUT drain, engine-side IN drain + OUT fill, err.
interface usb_ep_buf_mgr_if #(
    parameter int NUM_EP = 2,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int EP_W   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
);
    logic [EP_W-1:0]   app_ep;
    logic [ADDR_W-1:0] buf_in_addr;
    logic [DATA_W-1:0] buf_in_data;
    logic              buf_in_wren;
    logic              buf_in_ready;
    logic              buf_in_commit;
    logic [ADDR_W:0]   buf_in_commit_len;
    logic              buf_in_commit_ack;
    logic [ADDR_W-1:0] buf_out_addr;
    logic [DATA_W-1:0] buf_out_q;
    logic [ADDR_W:0]   buf_out_len;
    logic              buf_out_hasdata;
    logic              buf_out_arm;
    logic              buf_out_arm_ack;
    logic [EP_W-1:0]   usb_ep;
    logic [ADDR_W-1:0] usb_in_addr;
    logic [DATA_W-1:0] usb_in_q;
    logic [ADDR_W:0]   usb_in_len;
    logic              usb_in_hasdata;
    logic              usb_in_done;
    logic [ADDR_W-1:0] usb_out_addr;
    logic [DATA_W-1:0] usb_out_data;
    logic              usb_out_wren;
    logic              usb_out_ready;
    logic              usb_out_commit;
    logic [ADDR_W:0]   usb_out_len;
    logic              err_overflow;

    modport master (
        output app_ep, buf_in_addr, buf_in_data, buf_in_wren,
        output buf_in_commit, buf_in_commit_len, buf_out_addr, buf_out_arm,
        output usb_ep, usb_in_addr, usb_in_done, usb_out_addr,
        output usb_out_data, usb_out_wren, usb_out_commit, usb_out_len,
        input  buf_in_ready, buf_in_commit_ack, buf_out_q, buf_out_len,
        input  buf_out_hasdata, buf_out_arm_ack, usb_in_q, usb_in_len,
        input  usb_in_hasdata, usb_out_ready, err_overflow
    );

    modport slave (
        input  app_ep, buf_in_addr, buf_in_data, buf_in_wren,
        input  buf_in_commit, buf_in_commit_len, buf_out_addr, buf_out_arm,
        input  usb_ep, usb_in_addr, usb_in_done, usb_out_addr,
        input  usb_out_data, usb_out_wren, usb_out_commit, usb_out_len,
        output buf_in_ready, buf_in_commit_ack, buf_out_q, buf_out_len,
        output buf_out_hasdata, buf_out_arm_ack, usb_in_q, usb_in_len,
        output usb_in_hasdata, usb_out_ready, err_overflow
    );
endinterface

// File: rtl/usb_ep_buf_mgr.sv
// usb_ep_buf_mgr: per-endpoint ping-pong IN buffers and single OUT buffers.
// Ports: ext_clk, reset (sync, active-high), bus (usb_ep_buf_mgr_if.slave).
module usb_ep_buf_mgr #(
    parameter int NUM_EP = 2,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int EP_W   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic            ext_clk,
    input  logic            reset,
    usb_ep_buf_mgr_if.slave bus
);
    localparam int EP_N = 1 << EP_W;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {OUT_FREE, OUT_FULL} out_st_t;

    logic [DATA_W-1:0] in_mem  [2**(EP_W+1+ADDR_W)];
    logic [DATA_W-1:0] out_mem [2**(EP_W+ADDR_W)];

    logic [1:0]      in_full   [EP_N];
    logic [ADDR_W:0] in_len    [EP_N][2];
    logic            fill_ptr  [EP_N];
    logic            drain_ptr [EP_N];
    out_st_t         out_st    [EP_N];
    out_st_t         out_st_d  [EP_N];
    logic [ADDR_W:0] out_len   [EP_N];

    logic app_ok, usb_ok;
    logic app_fill, usb_drain;
    logic in_ready, in_avail, out_free;
    logic in_commit_ok, in_commit_bad, in_done_ok;
    logic out_commit_ok, out_commit_bad, arm_ok, clamp_err;

    function automatic logic [ADDR_W:0] clamp(input logic [ADDR_W:0] l);
        return (l > DEPTH) ? DEPTH : l;
    endfunction

    // Selects beyond NUM_EP only exist when NUM_EP is not a power of two.
    if (NUM_EP == EP_N) begin : g_full_range
        assign app_ok = 1'b1;
        assign usb_ok = 1'b1;
    end else begin : g_part_range
        assign app_ok = bus.app_ep < EP_W'(NUM_EP);
        assign usb_ok = bus.usb_ep < EP_W'(NUM_EP);
    end

    assign app_fill  = fill_ptr[bus.app_ep];
    assign usb_drain = drain_ptr[bus.usb_ep];

    assign in_ready = !reset && app_ok && !in_full[bus.app_ep][app_fill];
    assign in_avail = usb_ok && in_full[bus.usb_ep][usb_drain];
    assign out_free = usb_ok && (out_st[bus.usb_ep] == OUT_FREE);

    assign bus.buf_in_ready    = in_ready;
    assign bus.usb_in_hasdata  = in_avail;
    assign bus.usb_in_len      = in_len[bus.usb_ep][usb_drain];
    assign bus.usb_out_ready   = !reset && out_free;
    assign bus.buf_out_hasdata = app_ok && (out_st[bus.app_ep] == OUT_FULL);
    assign bus.buf_out_len     = out_len[bus.app_ep];

    assign in_commit_ok   = in_ready && bus.buf_in_commit;
    assign in_commit_bad  = app_ok && bus.buf_in_commit && !in_ready;
    assign in_done_ok     = in_avail && bus.usb_in_done;
    assign out_commit_ok  = out_free && bus.usb_out_commit;
    assign out_commit_bad = usb_ok && bus.usb_out_commit && !out_free;
    assign arm_ok         = app_ok && bus.buf_out_arm;
    assign clamp_err = (in_commit_ok && bus.buf_in_commit_len > DEPTH) ||
                       (out_commit_ok && bus.usb_out_len > DEPTH);

    // IN bank bookkeeping; done is applied before commit so a freed
    // bank that is refilled in the same cycle ends up full.
    always_ff @(posedge ext_clk) begin
        if (reset) begin
            for (int e = 0; e < EP_N; e++) begin
                in_full[e]   <= '0;
                fill_ptr[e]  <= 1'b0;
                drain_ptr[e] <= 1'b0;
                in_len[e][0] <= '0;
                in_len[e][1] <= '0;
            end
            bus.buf_in_commit_ack <= 1'b0;
            bus.buf_out_arm_ack   <= 1'b0;
            bus.err_overflow      <= 1'b0;
        end else begin
            if (in_done_ok) begin
                in_full[bus.usb_ep][usb_drain] <= 1'b0;
                drain_ptr[bus.usb_ep]          <= !usb_drain;
            end
            if (in_commit_ok) begin
                in_full[bus.app_ep][app_fill] <= 1'b1;
                in_len[bus.app_ep][app_fill]  <= clamp(bus.buf_in_commit_len);
                fill_ptr[bus.app_ep]          <= !app_fill;
            end
            bus.buf_in_commit_ack <= in_commit_ok;
            bus.buf_out_arm_ack   <= arm_ok;
            bus.err_overflow      <= in_commit_bad || out_commit_bad || clamp_err;
        end
    end

    // OUT state: arm is applied first, the engine commit (judged on the
    // pre-arm state) is applied last.
    always_comb begin
        for (int e = 0; e < EP_N; e++) begin
            out_st_d[e] = out_st[e];
        end
        if (arm_ok) begin
            out_st_d[bus.app_ep] = OUT_FREE;
        end
        if (out_commit_ok) begin
            out_st_d[bus.usb_ep] = OUT_FULL;
        end
    end

    always_ff @(posedge ext_clk) begin
        if (reset) begin
            for (int e = 0; e < EP_N; e++) begin
                out_st[e]  <= OUT_FREE;
                out_len[e] <= '0;
            end
        end else begin
            for (int e = 0; e < EP_N; e++) begin
                out_st[e] <= out_st_d[e];
            end
            if (out_commit_ok) begin
                out_len[bus.usb_ep] <= clamp(bus.usb_out_len);
            end
        end
    end

    // Buffer storage is not reset.
    always_ff @(posedge ext_clk) begin
        if (bus.buf_in_wren && in_ready) begin
            in_mem[{bus.app_ep, app_fill, bus.buf_in_addr}] <= bus.buf_in_data;
        end
        if (bus.usb_out_wren && out_free && !reset) begin
            out_mem[{bus.usb_ep, bus.usb_out_addr}] <= bus.usb_out_data;
        end
    end

    always_ff @(posedge ext_clk) begin
        if (reset) begin
            bus.usb_in_q  <= '0;
            bus.buf_out_q <= '0;
        end else begin
            bus.usb_in_q  <= usb_ok ?
                in_mem[{bus.usb_ep, usb_drain, bus.usb_in_addr}] : '0;
            bus.buf_out_q <= app_ok ?
                out_mem[{bus.app_ep, bus.buf_out_addr}] : '0;
        end
    end
endmodule

// File: tb/tb_usb_ep_buf_mgr.sv
// tb_usb_ep_buf_mgr: directed plus random stimulus against a packet-queue
// reference model of the endpoint buffer manager (3 endpoints, one invalid select).
module tb_usb_ep_buf_mgr;
    localparam int NUM_EP = 3;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int EP_W   = 2;
    localparam int LEN_W  = ADDR_W + 1;
    localparam int DEPTH  = 512;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    usb_ep_buf_mgr_if #(.NUM_EP(NUM_EP), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

    usb_ep_buf_mgr #(.NUM_EP(NUM_EP), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ext_clk(clk),
        .reset  (reset),
        .bus    (ifc.slave)
    );

    int total = 0;
    int passed = 0;
    int fails = 0;

    // Model: each IN endpoint is a FIFO of up to two committed packets plus
    // the packet being filled; each OUT endpoint holds at most one packet.
    int         inq_n   [NUM_EP];
    int         inq_id  [NUM_EP][2];
    int         fill_id [NUM_EP];
    bit         out_full[NUM_EP];
    int         out_lenm[NUM_EP];
    int         out_id  [NUM_EP];
    int         out_wid [NUM_EP];
    int         plen    [int];
    logic [7:0] pmem    [int];
    int         next_id = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic int clampf(input int l);
        return (l > DEPTH) ? DEPTH : l;
    endfunction

    task automatic model_reset();
        for (int e = 0; e < NUM_EP; e++) begin
            inq_n[e] = 0;
            out_full[e] = 1'b0;
            fill_id[e] = next_id;
            next_id++;
            out_wid[e] = next_id;
            next_id++;
        end
    endtask

    task automatic check_comb();
        int a, u;
        bit av, uv;
        a = int'(ifc.app_ep);
        u = int'(ifc.usb_ep);
        av = a < NUM_EP;
        uv = u < NUM_EP;
        chk("buf_in_ready", 32'(ifc.buf_in_ready), 32'(!reset && av && inq_n[a] < 2));
        chk("usb_in_hasdata", 32'(ifc.usb_in_hasdata), 32'(uv && inq_n[u] > 0));
        if (uv && inq_n[u] > 0)
            chk("usb_in_len", 32'(ifc.usb_in_len), plen[inq_id[u][0]]);
        chk("usb_out_ready", 32'(ifc.usb_out_ready), 32'(!reset && uv && !out_full[u]));
        chk("buf_out_hasdata", 32'(ifc.buf_out_hasdata), 32'(av && out_full[a]));
        if (av && out_full[a])
            chk("buf_out_len", 32'(ifc.buf_out_len), out_lenm[a]);
    endtask

    task automatic cycle();
        int a, u, key, lin, lout;
        bit av, uv, rst, in_ok, in_bad, done_ok, wr_in, wr_out;
        bit oc_ok, oc_bad, arm_ok, err_e, iq_chk, oq_chk;
        logic [7:0] iq_e, oq_e;
        a = int'(ifc.app_ep);
        u = int'(ifc.usb_ep);
        av = a < NUM_EP;
        uv = u < NUM_EP;
        rst = reset;
        lin = int'(ifc.buf_in_commit_len);
        lout = int'(ifc.usb_out_len);
        in_ok   = av && ifc.buf_in_commit && inq_n[a] < 2;
        in_bad  = av && ifc.buf_in_commit && inq_n[a] == 2;
        done_ok = uv && ifc.usb_in_done && inq_n[u] > 0;
        wr_in   = av && ifc.buf_in_wren && inq_n[a] < 2;
        wr_out  = uv && ifc.usb_out_wren && !out_full[u];
        oc_ok   = uv && ifc.usb_out_commit && !out_full[u];
        oc_bad  = uv && ifc.usb_out_commit && out_full[u];
        arm_ok  = av && ifc.buf_out_arm;
        err_e   = in_bad || (in_ok && lin > DEPTH) || oc_bad || (oc_ok && lout > DEPTH);
        iq_chk = 1'b0;
        oq_chk = 1'b0;
        iq_e = '0;
        oq_e = '0;
        if (uv && inq_n[u] > 0) begin
            key = inq_id[u][0] * 1024 + int'(ifc.usb_in_addr);
            if (pmem.exists(key)) begin
                iq_chk = 1'b1;
                iq_e = pmem[key];
            end
        end
        if (av && out_full[a]) begin
            key = out_id[a] * 1024 + int'(ifc.buf_out_addr);
            if (pmem.exists(key)) begin
                oq_chk = 1'b1;
                oq_e = pmem[key];
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (wr_in) pmem[fill_id[a] * 1024 + int'(ifc.buf_in_addr)] = ifc.buf_in_data;
            if (wr_out) pmem[out_wid[u] * 1024 + int'(ifc.usb_out_addr)] = ifc.usb_out_data;
            if (done_ok) begin
                inq_id[u][0] = inq_id[u][1];
                inq_n[u]--;
            end
            if (in_ok) begin
                plen[fill_id[a]] = clampf(lin);
                inq_id[a][inq_n[a]] = fill_id[a];
                inq_n[a]++;
                fill_id[a] = next_id;
                next_id++;
            end
            if (arm_ok) out_full[a] = 1'b0;
            if (oc_ok) begin
                out_full[u] = 1'b1;
                out_lenm[u] = clampf(lout);
                out_id[u] = out_wid[u];
                out_wid[u] = next_id;
                next_id++;
            end
        end
        chk("commit_ack", 32'(ifc.buf_in_commit_ack), 32'(!rst && in_ok));
        chk("arm_ack", 32'(ifc.buf_out_arm_ack), 32'(!rst && arm_ok));
        chk("err_overflow", 32'(ifc.err_overflow), 32'(!rst && err_e));
        if (rst) begin
            chk("usb_in_q_rst", 32'(ifc.usb_in_q), 0);
            chk("buf_out_q_rst", 32'(ifc.buf_out_q), 0);
        end else begin
            if (iq_chk) chk("usb_in_q", 32'(ifc.usb_in_q), 32'(iq_e));
            if (oq_chk) chk("buf_out_q", 32'(ifc.buf_out_q), 32'(oq_e));
        end
        check_comb();
    endtask

    task automatic in_fill(input int ep, input int n, input int base);
        ifc.app_ep = EP_W'(ep);
        for (int i = 0; i < n; i++) begin
            ifc.buf_in_wren = 1'b1;
            ifc.buf_in_addr = ADDR_W'(i);
            ifc.buf_in_data = DATA_W'(base + i);
            cycle();
        end
        ifc.buf_in_wren = 1'b0;
    endtask

    task automatic in_commit(input int ep, input int len);
        ifc.app_ep = EP_W'(ep);
        ifc.buf_in_commit = 1'b1;
        ifc.buf_in_commit_len = LEN_W'(len);
        cycle();
        ifc.buf_in_commit = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ifc.app_ep = '0;
        ifc.buf_in_addr = '0;
        ifc.buf_in_data = '0;
        ifc.buf_in_wren = 1'b0;
        ifc.buf_in_commit = 1'b0;
        ifc.buf_in_commit_len = '0;
        ifc.buf_out_addr = '0;
        ifc.buf_out_arm = 1'b0;
        ifc.usb_ep = '0;
        ifc.usb_in_addr = '0;
        ifc.usb_in_done = 1'b0;
        ifc.usb_out_addr = '0;
        ifc.usb_out_data = '0;
        ifc.usb_out_wren = 1'b0;
        ifc.usb_out_commit = 1'b0;
        ifc.usb_out_len = '0;
        model_reset();
        cycle();
        cycle();
        chk("ready_in_reset", 32'(ifc.buf_in_ready), 0);
        reset = 1'b0;
        cycle();
        chk("ready_after_reset", 32'(ifc.buf_in_ready), 1);
        chk("out_ready_after_reset", 32'(ifc.usb_out_ready), 1);

        // ep0: 64-byte packet, read back byte 5
        in_fill(0, 64, 0);
        in_commit(0, 64);
        chk("ep0_ack", 32'(ifc.buf_in_commit_ack), 1);
        ifc.usb_ep = '0;
        ifc.usb_in_addr = ADDR_W'(5);
        cycle();
        chk("ep0_hasdata", 32'(ifc.usb_in_hasdata), 1);
        chk("ep0_len", 32'(ifc.usb_in_len), 64);
        chk("ep0_q5", 32'(ifc.usb_in_q), 32'h05);

        // ep1: both banks full, third commit rejected, then drain one
        in_fill(1, 8, 8'h10);
        in_commit(1, 8);
        in_fill(1, 8, 8'h20);
        in_commit(1, 8);
        chk("ep1_both_full", 32'(ifc.buf_in_ready), 0);
        in_commit(1, 8);
        chk("ep1_third_noack", 32'(ifc.buf_in_commit_ack), 0);
        chk("ep1_third_err", 32'(ifc.err_overflow), 1);
        ifc.usb_ep = EP_W'(1);
        ifc.usb_in_done = 1'b1;
        cycle();
        ifc.usb_in_done = 1'b0;
        chk("ep1_ready_after_done", 32'(ifc.buf_in_ready), 1);
        chk("ep1_second_len", 32'(ifc.usb_in_len), 8);

        // ep0: commit and done in the same cycle
        in_fill(0, 4, 8'h40);
        ifc.usb_ep = '0;
        ifc.usb_in_done = 1'b1;
        in_commit(0, 4);
        ifc.usb_in_done = 1'b0;
        chk("ep0_same_cycle_ack", 32'(ifc.buf_in_commit_ack), 1);
        chk("ep0_same_cycle_len", 32'(ifc.usb_in_len), 4);

        // ep1 OUT: 16 bytes, arm twice, then an oversize commit
        ifc.usb_ep = EP_W'(1);
        ifc.app_ep = EP_W'(1);
        for (int i = 0; i < 16; i++) begin
            ifc.usb_out_wren = 1'b1;
            ifc.usb_out_addr = ADDR_W'(i);
            ifc.usb_out_data = DATA_W'(8'hA0 + i);
            cycle();
        end
        ifc.usb_out_wren = 1'b0;
        ifc.usb_out_commit = 1'b1;
        ifc.usb_out_len = LEN_W'(16);
        cycle();
        ifc.usb_out_commit = 1'b0;
        chk("out_hasdata", 32'(ifc.buf_out_hasdata), 1);
        chk("out_len16", 32'(ifc.buf_out_len), 16);
        chk("out_not_ready", 32'(ifc.usb_out_ready), 0);
        ifc.buf_out_addr = ADDR_W'(3);
        cycle();
        chk("out_q3", 32'(ifc.buf_out_q), 32'hA3);
        ifc.buf_out_arm = 1'b1;
        cycle();
        chk("arm_ack1", 32'(ifc.buf_out_arm_ack), 1);
        chk("arm_freed", 32'(ifc.usb_out_ready), 1);
        cycle();
        chk("arm_ack2", 32'(ifc.buf_out_arm_ack), 1);
        ifc.buf_out_arm = 1'b0;
        ifc.usb_out_commit = 1'b1;
        ifc.usb_out_len = LEN_W'(DEPTH + 1);
        cycle();
        ifc.usb_out_commit = 1'b0;
        chk("out_clamp_len", 32'(ifc.buf_out_len), DEPTH);
        chk("out_clamp_err", 32'(ifc.err_overflow), 1);
        cycle();
        chk("out_err_single", 32'(ifc.err_overflow), 0);

        // reset with ep0 IN both full and OUT full
        in_commit(0, 2);
        ifc.usb_ep = '0;
        ifc.usb_out_commit = 1'b1;
        ifc.usb_out_len = LEN_W'(3);
        cycle();
        ifc.usb_out_commit = 1'b0;
        chk("ep0_full_pre_reset", 32'(ifc.buf_in_ready), 0);
        reset = 1'b1;
        cycle();
        chk("rst_in_hasdata", 32'(ifc.usb_in_hasdata), 0);
        chk("rst_out_hasdata", 32'(ifc.buf_out_hasdata), 0);
        reset = 1'b0;
        cycle();
        chk("rst_ready", 32'(ifc.buf_in_ready), 1);

        // out-of-range selects: everything ignored, no error
        ifc.app_ep = EP_W'(3);
        ifc.usb_ep = EP_W'(3);
        ifc.buf_in_commit = 1'b1;
        ifc.usb_in_done = 1'b1;
        ifc.buf_out_arm = 1'b1;
        ifc.usb_out_commit = 1'b1;
        cycle();
        chk("oor_no_ack", 32'(ifc.buf_in_commit_ack), 0);
        chk("oor_no_err", 32'(ifc.err_overflow), 0);

        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            ifc.app_ep = EP_W'($urandom_range(0, 3));
            ifc.usb_ep = EP_W'($urandom_range(0, 3));
            ifc.buf_in_wren = 1'($urandom_range(0, 1));
            ifc.buf_in_addr = ADDR_W'($urandom_range(0, 15));
            ifc.buf_in_data = DATA_W'($urandom);
            ifc.buf_in_commit = ($urandom_range(0, 4) == 0);
            ifc.buf_in_commit_len = LEN_W'(($urandom_range(0, 7) == 0) ?
                $urandom_range(513, 1023) : $urandom_range(0, 20));
            ifc.usb_in_done = ($urandom_range(0, 3) == 0);
            ifc.usb_in_addr = ADDR_W'($urandom_range(0, 15));
            ifc.usb_out_wren = 1'($urandom_range(0, 1));
            ifc.usb_out_addr = ADDR_W'($urandom_range(0, 15));
            ifc.usb_out_data = DATA_W'($urandom);
            ifc.usb_out_commit = ($urandom_range(0, 4) == 0);
            ifc.usb_out_len = LEN_W'(($urandom_range(0, 7) == 0) ?
                $urandom_range(513, 1023) : $urandom_range(0, 20));
            ifc.buf_out_arm = ($urandom_range(0, 4) == 0);
            ifc.buf_out_addr = ADDR_W'($urandom_range(0, 15));
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/usb_ep_buf_mgr.md
Name: usb_ep_buf_mgr

Overview:
Multi-endpoint USB packet buffer manager between the application and the USB protocol engine. It is a parametrised successor to the single-endpoint buf_in/buf_out buffer.
- Per endpoint: a double-buffered (ping-pong) IN buffer filled by the application and drained by the protocol engine.
- Per endpoint: a single OUT buffer filled by the engine and drained by the application.
- Commit/ack handshakes, per-bank length tracking and overflow detection.

Parameters:
NUM_EP, 2, number of endpoints (1..16)
ADDR_W, 9, byte address width; each bank holds DEPTH = 2^ADDR_W bytes
DATA_W, 8, data width
EP_W, max(1,$clog2(NUM_EP)), endpoint select width (derived)

Ports:
ext_clk  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high
app_ep  in  EP_W  application-side endpoint select
buf_in_addr  in  ADDR_W  IN fill write address
buf_in_data  in  DATA_W  IN fill write data
buf_in_wren  in  1  IN fill write strobe
buf_in_ready  out  1  fill bank of app_ep free
buf_in_commit  in  1  pulse: fill bank complete
buf_in_commit_len  in  ADDR_W+1  committed byte count
buf_in_commit_ack  out  1  pulse, commit accepted
buf_out_addr  in  ADDR_W  OUT read address
buf_out_q  out  DATA_W  OUT read data
buf_out_len  out  ADDR_W+1  OUT packet length of app_ep
buf_out_hasdata  out  1  OUT buffer of app_ep full
buf_out_arm  in  1  pulse: release OUT buffer
buf_out_arm_ack  out  1  pulse, arm accepted
usb_ep  in  EP_W  engine-side endpoint select
usb_in_addr  in  ADDR_W  IN drain read address
usb_in_q  out  DATA_W  IN drain read data
usb_in_len  out  ADDR_W+1  length of drain bank
usb_in_hasdata  out  1  drain bank of usb_ep full
usb_in_done  in  1  pulse: drain bank transmitted and ACKed
usb_out_addr  in  ADDR_W  OUT write address
usb_out_data  in  DATA_W  OUT write data
usb_out_wren  in  1  OUT write strobe
usb_out_ready  out  1  OUT buffer of usb_ep free
usb_out_commit  in  1  pulse: OUT packet received good
usb_out_len  in  ADDR_W+1  received byte count
err_overflow  out  1  one-cycle pulse on any rejected commit or length clamp

Behaviour:
Reset:
- All banks empty; fill_ptr/drain_ptr = 0 for every endpoint; all pulses and q = 0.
- buf_in_ready/usb_out_ready forced 0 while reset is high; they read 1 the first cycle after reset.
- Memory contents are not reset.

IN path (per endpoint e: full[1:0], len[1:0], fill_ptr, drain_ptr):
- buf_in_ready = !full[fill_ptr] of app_ep.
- buf_in_wren with ready=1 writes bank fill_ptr; with ready=0 the write is dropped silently.
- buf_in_commit with ready=1: full[fill_ptr]<=1; len<=commit_len; fill_ptr toggles; buf_in_commit_ack=1 the next cycle.
- buf_in_commit with ready=0: ignored, no ack, err_overflow pulse.
- commit_len > DEPTH: clamped to DEPTH, commit still accepted, err_overflow pulse.
- usb_in_hasdata = full[drain_ptr] of usb_ep; usb_in_len is that bank's length.
- usb_in_done while hasdata: full[drain_ptr]<=0; drain_ptr toggles. usb_in_done while !hasdata: ignored.
- Commit and done on the same endpoint in the same cycle both take effect (different banks, or same bank freed and refilled); ready/hasdata reflect the new state the next cycle.
- Two commits with no done: both banks full, ready=0.

OUT path (per endpoint state FREE/FULL):
- usb_out_ready = (FREE).
- Writes are dropped when FULL.
- usb_out_commit in FREE: -> FULL, len latched (clamped as for IN, with err pulse).
- usb_out_commit in FULL: ignored, err_overflow pulse.
- buf_out_hasdata = (FULL).
- buf_out_arm in FULL: -> FREE. buf_out_arm in FREE: no state change.
- buf_out_arm_ack=1 the next cycle in both arm cases.
- Arm and usb_out_commit on the same endpoint in the same cycle: arm applies first, then the commit sees FREE only on the following cycle (commit rejected, err pulse).

Reads:
- buf_out_q and usb_in_q are registered, 1-cycle latency from address/endpoint.
- A read of the bank being written in the same cycle returns old data.

Endpoint selects:
- Out-of-range endpoint selects (>= NUM_EP): ready/hasdata = 0, all strobes ignored, no error.

Test Plan:
- After reset, app_ep=0, write 0x00..0x3F to addr 0..63, commit len=64 -> ack 1 cycle later; usb_ep=0 shows hasdata=1, len=64; read addr 5 returns 0x05 next cycle.
- Commit two 8-byte packets on ep1 with no done -> buf_in_ready=0; third commit -> no ack, err_overflow pulse; usb_in_done -> ready=1, hasdata=1 (second packet, len=8).
- Same-cycle buf_in_commit and usb_in_done on ep0, with one bank full -> ack issued, one bank full afterward, fill and drain pointers both toggled.
- Engine writes 16 bytes to ep1 OUT, commit len=16 -> buf_out_hasdata=1, len=16, usb_out_ready=0; buf_out_arm -> ack next cycle, hasdata=0, ready=1; second arm -> ack again, no change.
- usb_out_commit len=DEPTH+1 (513) -> len reads 512, err_overflow pulses once.
- Assert reset with ep0 both IN banks full and OUT FULL -> next cycle hasdata=0 on both paths, ready=1, pointers back to bank 0.
